// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Holds the entry layout used by the FIFO and the forwarding match helper.
package regwb_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // A reader address matches a pending write only if the entry is live and
  // the reader is not looking at the hardwired-zero register.
  function automatic logic fwd_match(input logic [ADDR_W-1:0] rd_addr,
                                     input logic [ADDR_W-1:0] ent_addr,
                                     input logic              ent_valid);
    return ent_valid && (rd_addr != ZERO_REG) && (rd_addr == ent_addr);
  endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Circular buffer of pending writebacks with head/tail pointers and an
// occupancy count. Exposes every slot ordered by age (index 0 = oldest) with
// a validity mask so the top level can search it for forwarding. Supports an
// in-place data overwrite of the youngest entry for write coalescing.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     overwrite,
  input  logic [DATA_W-1:0]        overwrite_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                ent_by_age [DEPTH],
  output logic [DEPTH-1:0]         ent_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // Entry storage: write a new tail entry, or patch the youngest entry's data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail_ptr] <= push_entry;
    end else if (overwrite) begin
      mem[tail_ptr - PTR_ONE].data <= overwrite_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_ONE;
      if (pop)  head_ptr <= head_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Age-ordered view of the buffer for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_by_age[i] = mem[head_ptr + PW'(i)];
      ent_valid[i]  = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side companion of the 32x64 register file. Buffers writeback
// requests, drains at most one per cycle into the registered DA/D/W write
// port, drops writes to the zero register, and forwards pending data to the
// SA/SB readers. Optional build macro: REGWB_COALESCE_EN (merge a request
// into the youngest queued entry when the destination matches).
module regfile_wb_queue
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   hold,
  output logic [ADDR_W-1:0]      DA,
  output logic [DATA_W-1:0]      D,
  output logic                   W,
  input  logic [ADDR_W-1:0]      SA,
  input  logic [ADDR_W-1:0]      SB,
  output logic                   fwd_a_hit,
  output logic [DATA_W-1:0]      fwd_a_data,
  output logic                   fwd_b_hit,
  output logic [DATA_W-1:0]      fwd_b_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             full;
  logic             pop;
  logic             coalesce;
  logic             fire;
  logic             push;
  logic             overwrite;
  wb_entry_t        push_entry;
  wb_entry_t        ent_by_age [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock          (clock),
    .reset_n        (reset_n),
    .push           (push),
    .push_entry     (push_entry),
    .overwrite      (overwrite),
    .overwrite_data (in_data),
    .pop            (pop),
    .count          (count),
    .ent_by_age     (ent_by_age),
    .ent_valid      (ent_valid)
  );

  // Handshake, zero-register filter, coalescing decision and drain request.
  always_comb begin
    full       = (count == CW'(DEPTH));
    pop        = !hold && (count != {CW{1'b0}});
    push_entry = '{addr: in_addr, data: in_data};
`ifdef REGWB_COALESCE_EN
    // If the only entry leaves this cycle, merging would lose the request,
    // so it is enqueued as a fresh entry instead.
    in_ready = !full ||
               ((count != {CW{1'b0}}) && (in_addr == ent_by_age[PW'(count - CW'(1))].addr));
    coalesce = (count != {CW{1'b0}}) &&
               (in_addr == ent_by_age[PW'(count - CW'(1))].addr) &&
               !(pop && (count == CW'(1)));
`else
    in_ready = !full;
    coalesce = 1'b0;
`endif
    fire = in_valid && in_ready;
    if (fire && (in_addr != ZERO_REG)) begin
      push      = !coalesce;
      overwrite = coalesce;
    end else begin
      push      = 1'b0;
      overwrite = 1'b0;
    end
  end

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      W  <= 1'b0;
      DA <= '0;
      D  <= '0;
    end else if (pop) begin
      W  <= 1'b1;
      DA <= ent_by_age[0].addr;
      D  <= ent_by_age[0].data;
    end else begin
      W  <= 1'b0;
    end
  end

  // Forwarding search: output stage first, then oldest to youngest so the
  // youngest matching entry is the last to overwrite the result.
  always_comb begin
    fwd_a_hit  = fwd_match(SA, DA, W);
    fwd_a_data = fwd_a_hit ? D : {DATA_W{1'b0}};
    fwd_b_hit  = fwd_match(SB, DA, W);
    fwd_b_data = fwd_b_hit ? D : {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      fwd_a_data = fwd_match(SA, ent_by_age[i].addr, ent_valid[i]) ? ent_by_age[i].data : fwd_a_data;
      fwd_a_hit  = fwd_match(SA, ent_by_age[i].addr, ent_valid[i]) ? 1'b1 : fwd_a_hit;
      fwd_b_data = fwd_match(SB, ent_by_age[i].addr, ent_valid[i]) ? ent_by_age[i].data : fwd_b_data;
      fwd_b_hit  = fwd_match(SB, ent_by_age[i].addr, ent_valid[i]) ? 1'b1 : fwd_b_hit;
    end
    empty = (count == {CW{1'b0}}) && !W;
  end

endmodule
